// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves data-memory wait, load-use and
// redirect conditions into PC / pipeline-register enables, flushes and bubbles.
module hazard_ctrl #(
   parameter int TIMEOUT = 200,
   parameter int WAIT_W  = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ifid_rs_i,
   input  logic [4:0]       ifid_rt_i,
   input  logic             ifid_uses_rt_i,
   input  logic             idex_memtoreg_i,
   input  logic [4:0]       idex_rt_i,
   input  logic             branch_taken_i,
   input  logic             jump_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_write_o,
   output logic             idex_bubble_o,
   output logic             exmem_write_o,
   output logic             memwb_bubble_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

   localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

   state_t            state, stateNext;
   logic [WAIT_W-1:0] waitCnt, waitCntNext;
   logic              freeze;
   logic              loadUse;
   logic              redirect;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   always_comb begin
      unique case (state)
         RUN:      freeze = dmem_req_i && !dmem_ack_i;
         MEM_WAIT: freeze = !dmem_ack_i;
         default:  freeze = 1'b1;
      endcase
   end

   // Register $0 never carries a value, so a load targeting it cannot hazard.
   assign loadUse = idex_memtoreg_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) ||
                     (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
   assign redirect = branch_taken_i || jump_i;

   always_comb begin
      stateNext   = state;
      waitCntNext = waitCnt;
      unique case (state)
         RUN: begin
            if (dmem_req_i && !dmem_ack_i) begin
               stateNext   = MEM_WAIT;
               waitCntNext = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ack_i) begin
               stateNext   = RUN;
               waitCntNext = '0;
            end else if (waitCnt == TIMEOUT_CNT) begin
               stateNext = ERROR;
            end else begin
               waitCntNext = waitCnt + 1'b1;
            end
         end
         default: stateNext = ERROR;
      endcase
   end

   // Outputs are Mealy so a stall blocks the very cycle it is detected in.
   always_comb begin
      pc_write_o     = 1'b1;
      ifid_write_o   = 1'b1;
      ifid_flush_o   = 1'b0;
      idex_write_o   = 1'b1;
      idex_bubble_o  = 1'b0;
      exmem_write_o  = 1'b1;
      memwb_bubble_o = 1'b0;
      if (rst_i) begin
         pc_write_o     = 1'b0;
         ifid_write_o   = 1'b0;
         idex_write_o   = 1'b0;
         idex_bubble_o  = 1'b1;
         exmem_write_o  = 1'b0;
         memwb_bubble_o = 1'b1;
      end else if (freeze) begin
         pc_write_o     = 1'b0;
         ifid_write_o   = 1'b0;
         idex_write_o   = 1'b0;
         exmem_write_o  = 1'b0;
         memwb_bubble_o = 1'b1;
      end else if (loadUse) begin
         // No flush here: the branch resolves again next cycle with forwarded data.
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (redirect) begin
         ifid_flush_o = 1'b1;
      end
   end

   assign err_o = (state == ERROR);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= RUN;
         waitCnt <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
      end else if (!pc_write_o) begin
         stall_cnt_o <= satInc(stall_cnt_o);
      end
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives write-enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three conditions with a fixed priority: data-memory wait stalls, load-use hazards, and branch/jump redirect flushes.
- Contains a wait FSM with a timeout, a sticky error flag and a saturating stall-cycle counter.

Parameters:
- TIMEOUT, 200: maximum number of MEM_WAIT cycles before the block declares an error (must be 1..2^WAIT_W-1).
- WAIT_W, 8: width of the wait counter.
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt_i  in  1  the IF/ID instruction reads rt as a source.
- idex_memtoreg_i  in  1  the ID/EX instruction is a load.
- idex_rt_i  in  5  destination register of the ID/EX load.
- branch_taken_i  in  1  branch resolved taken in ID.
- jump_i  in  1  jump decoded in ID.
- dmem_req_i  in  1  the MEM stage holds a load or store.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID clears to a NOP.
- idex_write_o  out  1  ID/EX load enable.
- idex_bubble_o  out  1  ID/EX control fields load zero (RegWrite, MemWrite, MemToReg = 0).
- exmem_write_o  out  1  EX/MEM load enable.
- memwb_bubble_o  out  1  MEM/WB control fields load zero.
- err_o  out  1  sticky memory-timeout error.
- stall_cnt_o  out  CNT_W  count of cycles with pc_write_o = 0.

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- While rst_i is high:
  - all write enables = 0, ifid_flush_o = 0, both bubbles = 1;
  - err_o = 0, stall_cnt_o = 0, wait_cnt = 0.
- Outputs are Mealy: combinational from the current state and current inputs, so a stall takes effect in the same cycle it is detected.
- freeze condition:
  - (RUN and dmem_req_i and !dmem_ack_i), or
  - (MEM_WAIT and !dmem_ack_i), or
  - ERROR.
- freeze outputs:
  - pc_write_o, ifid_write_o, idex_write_o, exmem_write_o = 0;
  - memwb_bubble_o = 1;
  - ifid_flush_o = 0, idex_bubble_o = 0 (ID/EX is held, not bubbled).
- load_use condition: idex_memtoreg_i and idex_rt_i != 0 and (idex_rt_i == ifid_rs_i or (ifid_uses_rt_i and idex_rt_i == ifid_rt_i)).
- load_use outputs (when not frozen):
  - pc_write_o = 0, ifid_write_o = 0, idex_bubble_o = 1;
  - idex_write_o = 1, exmem_write_o = 1;
  - ifid_flush_o = 0, because the branch is re-evaluated next cycle with the forwarded data.
- redirect condition (when not frozen and no load_use): branch_taken_i or jump_i.
- redirect outputs: ifid_flush_o = 1, all write enables = 1.
- Otherwise: all write enables = 1, flush = 0, bubbles = 0.
- Priority: freeze > load_use > redirect > normal.
- FSM transitions:
  - RUN -> MEM_WAIT when dmem_req_i and !dmem_ack_i; wait_cnt <= 1.
  - MEM_WAIT -> RUN when dmem_ack_i. The ack cycle is not frozen: load_use and redirect rules apply normally. wait_cnt <= 0.
  - MEM_WAIT with !dmem_ack_i and wait_cnt == TIMEOUT -> ERROR; otherwise wait_cnt increments.
  - ERROR is held until reset; err_o = 1 in ERROR.
- dmem_ack_i with !dmem_req_i in RUN is ignored.
- stall_cnt_o increments on every clock edge where pc_write_o = 0 and rst_i = 0. It saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-wait aborts the wait immediately: state goes to RUN and all counters clear.

Test Plan:
- Load-use stall: idex_memtoreg_i=1, idex_rt_i=5, ifid_rs_i=5, no memory request -> one cycle with pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. Next cycle, with idex_memtoreg_i=0, all enables return to 1. stall_cnt_o=1.
- Load to $0: idex_rt_i=0, ifid_rs_i=0, idex_memtoreg_i=1 -> no stall, pc_write_o=1.
- Taken branch under load-use: branch_taken_i=1 with the load-use condition true -> ifid_flush_o=0 and stall asserted. Next cycle, without the hazard and branch_taken_i still 1 -> ifid_flush_o=1.
- Memory wait: dmem_req_i=1, dmem_ack_i=0 for 3 cycles, then ack -> freeze for 3 cycles with memwb_bubble_o=1 and exmem_write_o=0. The ack cycle has all enables = 1. State returns to RUN. stall_cnt_o=3.
- Timeout: TIMEOUT=4, dmem_req_i=1 with no ack -> ERROR entered after the 4th MEM_WAIT cycle. err_o=1 and freeze persist until rst_i; err_o=0 after reset.
- Reset mid-wait: assert rst_i asynchronously during MEM_WAIT -> outputs go to reset values immediately without waiting for a clock edge. After release, state is RUN and stall_cnt_o=0.
